// File: rtl/fp_minmax_cmp_pipe.sv
// ============================================================================
// fp_minmax_cmp_pipe
// ----------------------------------------------------------------------------
// Two-stage pipelined single-precision execution stage for FMIN.S, FMAX.S,
// FEQ.S, FLT.S and FLE.S (plus optional FCLASS.S), following the RISC-V
// NaN rules. The stage sits between operand read/issue and writeback, holds
// its result under backpressure and accumulates the sticky NV flag.
//
// Optional feature: define FP_FCLASS_EN to enable op 5 = FCLASS.S on in1.
// Without it, op 5 is handled like the reserved ops (result 0, NV 0).
//
// Ports:
//   CLK         in   clock, rising edge
//   RSTn        in   asynchronous active-low reset
//   flush       in   synchronous kill of every in-flight op
//   in_valid    in   op offered
//   in_ready    out  stage can accept an op (no path from in_valid)
//   in_op       in   3-bit opcode: 0 FMIN, 1 FMAX, 2 FEQ, 3 FLT, 4 FLE,
//                    5 FCLASS (optional), 6-7 reserved
//   in_rd       in   destination tag carried with the op
//   in1, in2    in   binary32 operands rs1 / rs2
//   out_valid   out  result available (held with out_* until out_ready)
//   out_ready   in   writeback accepts the result
//   out_rd      out  destination tag of the result
//   out_data    out  FP value, or zero-extended 0/1 / class mask
//   out_invalid out  NV exception for this result
//   flags_nv    out  sticky accumulated NV
//   flags_clr   in   clears flags_nv (a coincident setting transfer wins)
// ============================================================================
module fp_minmax_cmp_pipe #(
    parameter int RD_W = 5
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [RD_W-1:0] in_rd,
    input  logic [31:0]     in1,
    input  logic [31:0]     in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RD_W-1:0] out_rd,
    output logic [31:0]     out_data,
    output logic            out_invalid,
    output logic            flags_nv,
    input  logic            flags_clr
);

    localparam logic [2:0]  OP_FMIN    = 3'd0;
    localparam logic [2:0]  OP_FMAX    = 3'd1;
    localparam logic [2:0]  OP_FEQ     = 3'd2;
    localparam logic [2:0]  OP_FLT     = 3'd3;
    localparam logic [2:0]  OP_FLE     = 3'd4;
`ifdef FP_FCLASS_EN
    localparam logic [2:0]  OP_FCLASS  = 3'd5;
`endif
    localparam logic [31:0] QNAN_CANON = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Operand classification and ordering helpers
    // ------------------------------------------------------------------
    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic f_is_snan(input logic [31:0] x);
        return f_is_nan(x) && !x[22];
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    // Sign-magnitude total order with -0 < +0. Magnitudes compare as plain
    // unsigned integers because binary32 exponent sits above the fraction.
    function automatic logic f_lt_total(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31])
            return a[31];
        else if (a[31])
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

`ifdef FP_FCLASS_EN
    function automatic logic [9:0] f_fclass(input logic [31:0] x);
        logic       s;
        logic [7:0] e;
        logic [22:0] f;
        logic [9:0] m;
        s = x[31];
        e = x[30:23];
        f = x[22:0];
        m = 10'd0;
        if (e == 8'hFF) begin
            if (f == 23'd0) begin
                if (s) m[0] = 1'b1;
                else   m[7] = 1'b1;
            end else if (f[22]) begin
                m[9] = 1'b1;
            end else begin
                m[8] = 1'b1;
            end
        end else if (e == 8'h00) begin
            if (f == 23'd0) begin
                if (s) m[3] = 1'b1;
                else   m[4] = 1'b1;
            end else begin
                if (s) m[2] = 1'b1;
                else   m[5] = 1'b1;
            end
        end else begin
            if (s) m[1] = 1'b1;
            else   m[6] = 1'b1;
        end
        return m;
    endfunction
`endif

    // Stage 1 registers (operands)
    logic            r_vld_p1;
    logic [2:0]      r_op_p1;
    logic [RD_W-1:0] r_rd_p1;
    logic [31:0]     r_a_p1;
    logic [31:0]     r_b_p1;

    // Stage 2 registers (result, drives the output port directly)
    logic            r_vld_p2;
    logic [RD_W-1:0] r_rd_p2;
    logic [31:0]     r_data_p2;
    logic            r_nv_p2;
    logic            r_flag_nv;

    logic            w_advance;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_a_nan;
    logic            w_b_nan;
    logic            w_a_snan;
    logic            w_b_snan;
    logic            w_both_zero;
    logic            w_lt_ab;
    logic            w_eq_ab;
    logic            w_any_nan;
    logic [31:0]     w_res_data;
    logic            w_res_nv;

    // S2 can take a new result when empty or when its current one leaves.
    assign w_advance  = ~r_vld_p2 | out_ready;
    assign in_ready   = ~r_vld_p1 | w_advance;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_vld_p2 & out_ready;

    assign out_valid   = r_vld_p2;
    assign out_rd      = r_rd_p2;
    assign out_data    = r_data_p2;
    assign out_invalid = r_nv_p2;
    assign flags_nv    = r_flag_nv;

    // ------------------------------------------------------------------
    // Stage 0 -> 1: operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_in_xfer && !flush) begin
            r_op_p1 <= in_op;
            r_rd_p1 <= in_rd;
            r_a_p1  <= in1;
            r_b_p1  <= in2;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2: min/max/compare evaluation
    // ------------------------------------------------------------------
    assign w_a_nan     = f_is_nan(r_a_p1);
    assign w_b_nan     = f_is_nan(r_b_p1);
    assign w_a_snan    = f_is_snan(r_a_p1);
    assign w_b_snan    = f_is_snan(r_b_p1);
    assign w_any_nan   = w_a_nan | w_b_nan;
    assign w_both_zero = f_is_zero(r_a_p1) & f_is_zero(r_b_p1);
    assign w_lt_ab     = f_lt_total(r_a_p1, r_b_p1);
    assign w_eq_ab     = (r_a_p1 == r_b_p1) | w_both_zero;

    always_comb begin
        w_res_data = 32'd0;
        w_res_nv   = 1'b0;
        case (r_op_p1)
            OP_FMIN, OP_FMAX: begin
                if (w_a_nan && w_b_nan)
                    w_res_data = QNAN_CANON;
                else if (w_a_nan)
                    w_res_data = r_b_p1;
                else if (w_b_nan)
                    w_res_data = r_a_p1;
                else if (r_op_p1 == OP_FMIN)
                    w_res_data = w_lt_ab ? r_a_p1 : r_b_p1;
                else
                    w_res_data = w_lt_ab ? r_b_p1 : r_a_p1;
                w_res_nv = w_a_snan | w_b_snan;
            end
            OP_FEQ: begin
                w_res_data = {31'd0, ~w_any_nan & w_eq_ab};
                w_res_nv   = w_a_snan | w_b_snan;
            end
            // For compares the total order's -0 < +0 must not count.
            OP_FLT: begin
                w_res_data = {31'd0, ~w_any_nan & w_lt_ab & ~w_both_zero};
                w_res_nv   = w_any_nan;
            end
            OP_FLE: begin
                w_res_data = {31'd0, ~w_any_nan & ((w_lt_ab & ~w_both_zero) | w_eq_ab)};
                w_res_nv   = w_any_nan;
            end
`ifdef FP_FCLASS_EN
            OP_FCLASS: begin
                w_res_data = {22'd0, f_fclass(r_a_p1)};
                w_res_nv   = 1'b0;
            end
`endif
            default: begin
                w_res_data = 32'd0;
                w_res_nv   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control, result register and sticky flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_rd_p2   <= '0;
            r_data_p2 <= 32'd0;
            r_nv_p2   <= 1'b0;
            r_flag_nv <= 1'b0;
        end else begin
            if (flush) begin
                r_vld_p1 <= 1'b0;
                r_vld_p2 <= 1'b0;
            end else begin
                if (w_advance)
                    r_vld_p2 <= r_vld_p1;
                if (in_ready)
                    r_vld_p1 <= in_valid;
            end

            // Result payload only moves with a real op so out_* stay put
            // while the result waits for out_ready.
            if (!flush && w_advance && r_vld_p1) begin
                r_rd_p2   <= r_rd_p1;
                r_data_p2 <= w_res_data;
                r_nv_p2   <= w_res_nv;
            end

            // Set has priority over clear.
            if (w_out_xfer && r_nv_p2)
                r_flag_nv <= 1'b1;
            else if (flags_clr)
                r_flag_nv <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_minmax_cmp_pipe.sv
module tb_fp_minmax_cmp_pipe;

    localparam int RD_W = 5;

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = 3'd0;
    logic [RD_W-1:0] in_rd = '0;
    logic [31:0]     in1 = 32'd0;
    logic [31:0]     in2 = 32'd0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [RD_W-1:0] out_rd;
    logic [31:0]     out_data;
    logic            out_invalid;
    logic            flags_nv;
    logic            flags_clr = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    fp_minmax_cmp_pipe #(.RD_W(RD_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_invalid(out_invalid),
        .flags_nv(flags_nv), .flags_clr(flags_clr)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        nv;
    } vec_t;

    localparam int NV = 21;
    vec_t vt[NV];

`ifdef FP_FCLASS_EN
    localparam logic [31:0] FCLASS_NINF = 32'h0000_0001;
`else
    localparam logic [31:0] FCLASS_NINF = 32'h0000_0000;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Offer one op with out_ready high; return the result when out_valid
    // appears (lat = edges after offer, -1 if none within budget).
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd, output logic [31:0] d, output logic nv,
                         output logic [RD_W-1:0] ord, output int lat);
        in_op = op; in1 = a; in2 = b; in_rd = rd; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        lat = -1; d = '0; nv = 1'b0; ord = '0;
        for (int i = 1; i <= 6; i++) begin
            if (out_valid) begin
                lat = i; d = out_data; nv = out_invalid; ord = out_rd;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    logic [31:0]     r_d;
    logic            r_nv;
    logic [RD_W-1:0] r_rd;
    int              r_lat;
    logic            fl_before;

    initial begin
        vt[0]  = '{3'd1, 32'h3F800000, 32'hC0000000, 32'h3F800000, 1'b0};
        vt[1]  = '{3'd0, 32'h7F800001, 32'h40400000, 32'h40400000, 1'b1};
        vt[2]  = '{3'd1, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0};
        vt[3]  = '{3'd1, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0};
        vt[4]  = '{3'd0, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0};
        vt[5]  = '{3'd2, 32'h00000000, 32'h80000000, 32'h00000001, 1'b0};
        vt[6]  = '{3'd3, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1};
        vt[7]  = '{3'd2, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0};
        vt[8]  = '{3'd3, 32'hC0000000, 32'hBF800000, 32'h00000001, 1'b0};
        vt[9]  = '{3'd4, 32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0};
        vt[10] = '{3'd3, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0};
        vt[11] = '{3'd0, 32'hBF800000, 32'h3F800000, 32'hBF800000, 1'b0};
        vt[12] = '{3'd1, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 1'b0};
        vt[13] = '{3'd0, 32'h7FC00000, 32'h40400000, 32'h40400000, 1'b0};
        vt[14] = '{3'd1, 32'h7F800001, 32'h7FC00000, 32'h7FC00000, 1'b1};
        vt[15] = '{3'd2, 32'h7F800001, 32'h7F800001, 32'h00000000, 1'b1};
        vt[16] = '{3'd4, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0};
        vt[17] = '{3'd3, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
        vt[18] = '{3'd6, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0};
        vt[19] = '{3'd5, 32'hFF800000, 32'h00000000, FCLASS_NINF,  1'b0};
        vt[20] = '{3'd4, 32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst out_valid",   {31'd0, out_valid},   32'd0);
        chk("rst out_data",    out_data,             32'd0);
        chk("rst out_rd",      {27'd0, out_rd},      32'd0);
        chk("rst out_invalid", {31'd0, out_invalid}, 32'd0);
        chk("rst flags_nv",    {31'd0, flags_nv},    32'd0);
        chk("rst in_ready",    {31'd0, in_ready},    32'd1);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Table-driven single ops
        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, RD_W'(i), r_d, r_nv, r_rd, r_lat);
            chk($sformatf("v%0d latency", i), r_lat, 32'd2);
            chk($sformatf("v%0d data", i), r_d, vt[i].d);
            chk($sformatf("v%0d nv", i), {31'd0, r_nv}, {31'd0, vt[i].nv});
            chk($sformatf("v%0d rd", i), {27'd0, r_rd}, i);
        end

        // flags: last vector raises NV on its transfer while clr is held
        flags_clr = 1'b1;
        @(posedge CLK); #1;
        chk("flags set beats clr", {31'd0, flags_nv}, 32'd1);
        @(posedge CLK); #1;
        flags_clr = 1'b0;
        chk("flags clr no nv", {31'd0, flags_nv}, 32'd0);
        do_op(3'd0, 32'h7F800001, 32'h40400000, 5'd3, r_d, r_nv, r_rd, r_lat);
        chk("flags before xfer", {31'd0, flags_nv}, 32'd0);
        @(posedge CLK); #1;
        chk("flags after xfer", {31'd0, flags_nv}, 32'd1);

        // Backpressure: 4 back-to-back ops, out_ready low for 5 cycles
        begin
            int idx, recv, first_cyc;
            logic acc, oxf;
            logic [31:0] exp_d [4];
            for (int k = 0; k < 4; k++) exp_d[k] = 32'h40000000 + 32'(k) * 32'h00100000;
            idx = 0; recv = 0; first_cyc = -1;
            out_ready = 1'b0;
            for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
                if (cyc >= 2 && cyc < 5) begin
                    chk($sformatf("stall%0d in_ready", cyc), {31'd0, in_ready}, 32'd0);
                    chk($sformatf("stall%0d accepted", cyc), idx, 32'd2);
                    chk($sformatf("stall%0d out_valid", cyc), {31'd0, out_valid}, 32'd1);
                    chk($sformatf("stall%0d out_data", cyc), out_data, exp_d[0]);
                end
                out_ready = (cyc >= 5);
                in_valid  = (idx < 4);
                in_op = 3'd1; in1 = exp_d[idx < 4 ? idx : 0]; in2 = 32'h3F800000;
                in_rd = RD_W'(10 + idx);
                #1;
                acc = in_valid & in_ready;
                oxf = out_valid & out_ready;
                if (oxf) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    chk($sformatf("bp out%0d data", recv), out_data, exp_d[recv]);
                    chk($sformatf("bp out%0d cycle", recv), cyc, first_cyc + recv);
                    recv++;
                end
                @(posedge CLK); #1;
                if (acc) idx++;
            end
            in_valid = 1'b0;
            chk("bp results received", recv, 32'd4);
        end
        @(posedge CLK); #1;

        // flush with two ops in flight (one held in S2, one in S1)
        out_ready = 1'b0;
        in_op = 3'd3; in1 = 32'h7FC00000; in2 = 32'h0; in_rd = 5'd20; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_op = 3'd1; in1 = 32'h40A00000; in_rd = 5'd21;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("flush pre out_valid", {31'd0, out_valid}, 32'd1);
        fl_before = flags_nv;
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush flags kept", {31'd0, flags_nv}, {31'd0, fl_before});
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("flush lost%0d", c), {31'd0, out_valid}, 32'd0);
            @(posedge CLK); #1;
        end

        // flush drops a coincident input transfer
        in_op = 3'd1; in1 = 32'h40A00000; in2 = 32'h0; in_rd = 5'd22; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_rd = 5'd23; flush = 1'b1;
        chk("flush2 in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("flush2 lost%0d", c), {31'd0, out_valid}, 32'd0);
            @(posedge CLK); #1;
        end

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        in_op = 3'd0; in1 = 32'h3F800000; in2 = 32'h40000000; in_rd = 5'd24; in_valid = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("arst pre out_valid", {31'd0, out_valid}, 32'd1);
        RSTn = 1'b0;
        #1;
        chk("arst out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst out_data", out_data, 32'd0);
        chk("arst flags_nv", {31'd0, flags_nv}, 32'd0);
        #1;
        RSTn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1;
            chk($sformatf("arst quiet%0d", c), {31'd0, out_valid}, 32'd0);
        end

        // Pipeline still works after everything above
        do_op(3'd1, 32'hC0400000, 32'hC0000000, 5'd7, r_d, r_nv, r_rd, r_lat);
        chk("post data", r_d, 32'hC0000000);
        chk("post latency", r_lat, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
